alu_sequencer: RTL and testbench

Sequential front end for the combinational 64-bit ALU. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It issues each command to the ALU through registered operand/opcode outputs, captures the ALU result a cycle later, and returns it with carry/zero/error status over a second valid/ready handshake. Results return strictly in command order, with at most one operation in flight.

---
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: FIFO-buffered valid/ready front end for the 64-bit combinational ALU,
// one operation in flight, in-order results. Define ALU_SEQ_STATS_EN for stat_done/stat_err.
module alu_sequencer #(
  parameter int N     = 63,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N:0]   cmd_a,
  input  logic [N:0]   cmd_b,
  input  logic [3:0]   cmd_op,
  output logic [N:0]   alu_a,
  output logic [N:0]   alu_b,
  output logic [3:0]   alu_op,
  input  logic [N+1:0] alu_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N+1:0] rsp_y,
  output logic         rsp_carry,
  output logic         rsp_zero,
  output logic         rsp_err
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]  stat_done,
  output logic [15:0]  stat_err
`endif
);
  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = 2 * (N + 1) + 4;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [N:0]    r_alu_a, r_alu_b;
  logic [3:0]    r_alu_op;
  logic          r_rsp_valid, r_rsp_carry, r_rsp_zero, r_rsp_err;
  logic [N+1:0]  r_rsp_y;

  logic          w_empty, w_push, w_pop, w_rsp_hs, w_err;
  logic [CW-1:0] w_head;

  assign w_empty   = (r_count == '0);
  assign cmd_ready = (r_count != FULL);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || w_rsp_hs);
  assign w_head    = r_mem[r_rd_ptr];

  // Illegal opcodes and divide/modulus by zero are judged on the issued operands.
  assign w_err = (r_alu_op == 4'b0101) || (r_alu_op >= 4'b1010) ||
                 (((r_alu_op == 4'b0011) || (r_alu_op == 4'b0100)) && (r_alu_b == '0));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_alu_a, r_alu_b, r_alu_op} <= w_head;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
          if (w_err) begin
            r_rsp_y     <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else begin
            r_rsp_y     <= alu_y;
            r_rsp_carry <= alu_y[N+1];
            r_rsp_zero  <= (alu_y == '0);
            r_rsp_err   <= 1'b0;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
              {r_alu_a, r_alu_b, r_alu_op} <= w_head;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] r_stat_done, r_stat_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_done <= '0;
      r_stat_err  <= '0;
    end else if (w_rsp_hs) begin
      if (r_stat_done != '1)             r_stat_done <= r_stat_done + 1'b1;
      if (r_rsp_err && r_stat_err != '1) r_stat_err  <= r_stat_err + 1'b1;
    end
  end

  assign stat_done = r_stat_done;
  assign stat_err  = r_stat_err;
`endif

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign rsp_carry = r_rsp_carry;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a small ALU model.
// Stat counter checks are compiled in only when ALU_SEQ_STATS_EN is defined.
module tb_alu_sequencer;
  localparam int N     = 63;
  localparam int DEPTH = 4;

  logic         clk, rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic         rsp_carry, rsp_zero, rsp_err;
  logic [N:0]   cmd_a, cmd_b, alu_a, alu_b;
  logic [3:0]   cmd_op, alu_op;
  logic [N+1:0] alu_y, rsp_y, all_ones;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]  stat_done, stat_err;
`endif
  int n_checks, n_errors, n_acc;

  alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
`ifdef ALU_SEQ_STATS_EN
    , .stat_done(stat_done), .stat_err(stat_err)
`endif
  );

  // Add/sub modelled exactly; other opcodes return nonzero junk so the error override shows.
  always_comb begin
    case (alu_op)
      4'b0000: alu_y = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: alu_y = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_y = {1'b1, alu_a ^ alu_b ^ 64'hA5A5_A5A5_A5A5_A5A5};
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [N+1:0] obs, input logic [N+1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance one edge; drop cmd_valid if the command was taken at that edge.
  task automatic tick_cmd;
    logic acc;
    acc = cmd_valid && cmd_ready;
    tick();
    if (acc) cmd_valid = 1'b0;
  endtask

  task automatic offer(input logic [N:0] a, input logic [N:0] b, input logic [3:0] op);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [N:0] a, input logic [N:0] b,
                        input logic [3:0] op, input logic [N+1:0] y, input logic err);
    rsp_ready = 1'b1;
    offer(a, b, op);
    for (int c = 0; c < 20 && !cmd_ready; c++) tick();
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    tick_cmd();
    for (int c = 0; c < 20 && !rsp_valid; c++) tick();
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_y"},     rsp_y, y);
    chk({tag, "_carry"}, rsp_carry, y[N+1]);
    chk({tag, "_zero"},  rsp_zero, (y == '0));
    chk({tag, "_err"},   rsp_err, err);
    tick();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_acc = 0;
    all_ones = '1;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    tick();

    // Add with latency: accepted at edge k, response visible after edge k+2.
    rsp_ready = 1'b1;
    offer(64'd5, 64'd7, 4'b0000);
    chk("add_cmd_ready", cmd_ready, 1);
    tick_cmd();
    chk("add_lat_k", rsp_valid, 0);
    tick();
    chk("add_lat_k1", rsp_valid, 0);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 7);
    tick();
    chk("add_valid", rsp_valid, 1);
    chk("add_y", rsp_y, 12);
    chk("add_carry", rsp_carry, 0);
    chk("add_zero", rsp_zero, 0);
    chk("add_err", rsp_err, 0);
    tick();
    chk("add_consumed", rsp_valid, 0);

    run_op("sub_uflow", 64'd0, 64'd1, 4'b0001, all_ones, 1'b0);
    run_op("div0", 64'd9, 64'd0, 4'b0011, '0, 1'b1);
`ifdef ALU_SEQ_STATS_EN
    chk("stat_done", stat_done, 3);
    chk("stat_err", stat_err, 1);
`endif
    run_op("op0101", 64'd2, 64'd3, 4'b0101, '0, 1'b1);

    // Backpressure: one in flight plus DEPTH queued, the sixth is refused.
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(64'(i + 1), 64'(i), 4'b0000);
      chk($sformatf("bp_ready%0d", i), cmd_ready, (i < 5) ? 1 : 0);
      if (cmd_ready) n_acc++;
      if (i < 5) tick_cmd();
    end
    chk("bp_accepted", 66'(n_acc), 5);
    for (int h = 0; h < 3; h++) begin
      chk($sformatf("bp_hold_valid%0d", h), rsp_valid, 1);
      chk($sformatf("bp_hold_y%0d", h), rsp_y, 1);
      tick_cmd();
    end
    rsp_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("bp_res_valid%0d", j), rsp_valid, 1);
      chk($sformatf("bp_res_y%0d", j), rsp_y, 66'(2 * j + 1));
      tick_cmd();
      chk($sformatf("bp_gap%0d", j), rsp_valid, 0);
      if (j < 5) tick_cmd();
    end
    chk("bp_drained_ready", cmd_ready, 1);

    // Reset while a response is pending with three commands queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(64'(10 + i), 64'd0, 4'b0000);
      tick_cmd();
    end
    chk("mid_pre_valid", rsp_valid, 1);
    chk("mid_pre_y", rsp_y, 10);
    chk("mid_pre_ready", cmd_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_y", rsp_y, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_op", alu_op, 0);
`ifdef ALU_SEQ_STATS_EN
    chk("mid_rst_stat_done", stat_done, 0);
`endif
    tick();
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("post_rst_valid%0d", c), rsp_valid, 0);
    end
    chk("post_rst_alu_a", alu_a, 0);
    run_op("post_rst_add", 64'd3, 64'd4, 4'b0000, 66'd7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
